// File: rtl/cpu_mem_pkg.sv
// Shared types for the IF/MEM memory-port arbiter:
// FSM states, owner encoding, default widths.
package cpu_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_st_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter; o_last flags the final count.
module mem_arb_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM single-port memory arbiter with fixed-latency sequencer.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long IF can be held off.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
  end

  arb_st_e       r_state;
  arb_st_e       w_nxt;
  owner_e        r_own;
  owner_e        w_gown;
  logic          r_we;
  logic          w_grant;
  logic          w_gwe;
  logic          w_last;
  logic          w_cap;
  logic          w_force_if;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_done;
  logic          r_d_done;
  logic          r_busy;

  mem_arb_lat_cnt #(.W(CW)) u_lat (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == ST_ISSUE),
    .i_val  (CW'(MEM_LAT)),
    .i_dec  (r_state == ST_WAIT),
    .o_last (w_last)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;

  // Counts MEM wins while IF is waiting; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!if_req) begin
      r_starve <= '0;
    end else if (w_grant && w_gown == OWN_IF) begin
      r_starve <= '0;
    end else if (w_grant && r_starve != SW'(STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign w_force_if = if_req && (r_starve == SW'(STARVE_MAX));
`else
  assign w_force_if = 1'b0;
`endif

  always_comb begin
    w_nxt   = r_state;
    w_grant = 1'b0;
    w_gown  = OWN_IF;
    unique case (r_state)
      ST_IDLE: begin
        if (d_req && !w_force_if) begin
          w_grant = 1'b1;
          w_gown  = OWN_D;
          w_nxt   = ST_ISSUE;
        end else if (if_req) begin
          w_grant = 1'b1;
          w_gown  = OWN_IF;
          w_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: w_nxt = ST_WAIT;
      ST_WAIT:  if (w_last) w_nxt = ST_DONE;
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  assign w_gwe = (w_gown == OWN_D) && d_we;
  assign w_cap = (r_state == ST_WAIT) && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_own       <= OWN_IF;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_mem_en  <= w_grant;
      r_mem_we  <= w_grant & w_gwe;
      r_busy    <= (w_nxt != ST_IDLE);
      r_if_done <= w_cap && (r_own == OWN_IF);
      r_d_done  <= w_cap && (r_own == OWN_D);
      if (w_grant) begin
        r_own       <= w_gown;
        r_we        <= w_gwe;
        r_mem_addr  <= (w_gown == OWN_D) ? d_addr : if_addr;
        r_mem_wdata <= (w_gown == OWN_D) ? d_wdata : '0;
      end
      if (w_cap && !r_we) begin
        if (r_own == OWN_IF) r_if_rdata <= mem_rdata;
        else                 r_d_rdata  <= mem_rdata;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign busy      = r_busy;
  assign if_stall  = if_req & ~r_if_done;
  assign d_stall   = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model plus
// directed scenarios with hand-computed cycle/data expectations.
module tb_mem_port_arbiter;

  localparam int L = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, d_done, d_stall;
  logic        mem_en, mem_we, busy;

  logic        if_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [15:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic [15:0] mem_rdata1 = 16'hDEAD;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_done1, if_stall1, d_done1, d_stall1;
  logic        mem_en1, mem_we1, busy1;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(L), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
    .if_done(if_done1), .if_stall(if_stall1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_done(d_done1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, a, e);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hC3C3);
  endfunction

  // Memory attached to the DUT pins: data only in cycle en+L.
  logic [15:0] bmem [logic [15:0]];
  int          p_at = -10;
  logic [15:0] p_addr = '0;
  logic        p_we = 1'b0;
  int          p1_at = -10;

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      p_at   = cyc + L;
      p_addr = mem_addr;
      p_we   = mem_we;
      if (mem_we === 1'b1) bmem[mem_addr] = mem_wdata;
    end
    if (mem_en1 === 1'b1) p1_at = cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (cyc == p_at && !p_we)
      mem_rdata = bmem.exists(p_addr) ? bmem[p_addr] : init_val(p_addr);
    else
      mem_rdata = 16'hDEAD;
    mem_rdata1 = (cyc == p1_at) ? 16'h5A5A : 16'hDEAD;
  end

  // Reference model: each grant occupies a fixed L+3 cycle window.
  logic [15:0] gmem [logic [15:0]];
  bit          m_act = 1'b0;
  int          m_ti = 0;
  bit          m_own_d = 1'b0, m_we = 1'b0;
  logic [15:0] m_addr = '0, m_wd = '0, m_maddr = '0;
  logic [15:0] m_ifr = '0, m_dr = '0, m_v;
  int          m_starve = 0;
  bit          e_en, e_busy, e_ifd, e_dd, m_force;

  int          en_cyc = -1, ifd_cyc = -1, dd_cyc = -1;
  int          n_ifd = 0, n_dd = 0;
  logic        en_we = 1'b0;
  logic [15:0] en_addr = '0, en_wd = '0;

  always @(negedge clk) begin
    e_en = 0; e_busy = 0; e_ifd = 0; e_dd = 0;
    if (rst) begin
      m_act = 0; m_maddr = '0; m_ifr = '0; m_dr = '0; m_starve = 0;
    end else begin
      if (m_act && cyc >= m_ti + L + 3) m_act = 0;
      if (m_act) begin
        e_en   = (cyc == m_ti + 1);
        e_busy = (cyc > m_ti);
        if (e_en) m_maddr = m_addr;
        if (cyc == m_ti + L + 2) begin
          if (m_own_d) e_dd = 1; else e_ifd = 1;
          if (!m_we) begin
            m_v = gmem.exists(m_addr) ? gmem[m_addr] : init_val(m_addr);
            if (m_own_d) m_dr = m_v; else m_ifr = m_v;
          end
        end
      end
    end
    chk("mem_en", mem_en, e_en);
    chk("busy", busy, e_busy);
    chk("if_done", if_done, e_ifd);
    chk("d_done", d_done, e_dd);
    chk("if_stall", if_stall, if_req & ~e_ifd);
    chk("d_stall", d_stall, d_req & ~e_dd);
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
    chk("mem_addr", mem_addr, m_maddr);
    if (e_en) begin
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
    end
    if (mem_en === 1'b1) begin
      en_cyc = cyc; en_we = mem_we; en_addr = mem_addr; en_wd = mem_wdata;
    end
    if (if_done === 1'b1) begin ifd_cyc = cyc; n_ifd++; end
    if (d_done === 1'b1) begin dd_cyc = cyc; n_dd++; end
    if (!rst) begin
      m_force = GUARD && if_req && (m_starve >= 4);
      if (!m_act && d_req && !m_force) begin
        m_act = 1; m_ti = cyc; m_own_d = 1; m_we = d_we;
        m_addr = d_addr; m_wd = d_wdata;
        if (d_we) gmem[d_addr] = d_wdata;
        if (if_req && m_starve < 4) m_starve++;
      end else if (!m_act && if_req) begin
        m_act = 1; m_ti = cyc; m_own_d = 0; m_we = 0;
        m_addr = if_addr; m_wd = '0;
        m_starve = 0;
      end
      if (!if_req) m_starve = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_d, input string n, output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((is_d ? d_done : if_done) === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done within 60 cycles", n);
    end
  endtask

  int  t0, c, nd, n0;
  bit  seen;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    step();
    rst = 1'b0;

    // Single IF fetch
    step();
    t0 = cyc; if_addr = 16'h0010; if_req = 1;
    wait_done(0, "t1_if", c);
    chk("t1_done_cyc", c - t0, 4);
    chk("t1_en_cyc", en_cyc - t0, 1);
    chk("t1_en_addr", en_addr, 16'h0010);
    chk("t1_rdata", if_rdata, 16'h1234);

    // MEM-stage write, then read-back
    step();
    if_req = 0;
    t0 = cyc; d_req = 1; d_we = 1; d_addr = 16'h00A0; d_wdata = 16'hBEEF;
    wait_done(1, "t2_wr", c);
    chk("t2_done_cyc", c - t0, 4);
    chk("t2_en_cyc", en_cyc - t0, 1);
    chk("t2_en_we", en_we, 1);
    chk("t2_en_addr", en_addr, 16'h00A0);
    chk("t2_en_wdata", en_wd, 16'hBEEF);
    chk("t2_d_rdata_kept", d_rdata, 0);
    step();
    t0 = cyc; d_we = 0;
    wait_done(1, "t2_rd", c);
    chk("t2b_done_cyc", c - t0, 4);
    chk("t2b_rdata", d_rdata, 16'hBEEF);

    // Simultaneous requests: MEM first, then IF
    step();
    d_req = 0;
    step();
    t0 = cyc; if_addr = 16'h0020; if_req = 1; d_req = 1; d_addr = 16'h00A0;
    wait_done(1, "t3_d", c);
    chk("t3_d_done_cyc", c - t0, 4);
    step();
    d_req = 0;
    wait_done(0, "t3_if", c);
    chk("t3_if_done_cyc", c - t0, 9);
    chk("t3_if_en_cyc", en_cyc - t0, 6);
    chk("t3_if_rdata", if_rdata, 16'hC3E3);
    step();
    if_req = 0;

    // Continuous MEM traffic with a waiting IF
    step();
    if_addr = 16'h0010; if_req = 1; d_addr = 16'h0050; d_req = 1;
    nd = 0; seen = 0;
    for (int i = 0; i < 80 && !seen && nd < 8; i++) begin
      @(negedge clk);
      if (d_done === 1'b1) nd++;
      if (if_done === 1'b1) seen = 1;
    end
    chk("t4_d_before_if", nd, GUARD ? 4 : 8);
    chk("t4_if_served", seen, GUARD);
    step();
    d_req = 0;
    if (seen) begin
      if_req = 0;
    end else begin
      wait_done(0, "t4_if", c);
      step();
      if_req = 0;
    end

    // Reset in the middle of a read
    step();
    t0 = cyc; if_addr = 16'h0030; if_req = 1;
    step();
    step();
    n0 = n_ifd;
    rst = 1;
    @(negedge clk);
    chk("t5_rst_mem_en", mem_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_if_done", if_done, 0);
    chk("t5_rst_if_stall", if_stall, 1);
    step();
    rst = 0;
    wait_done(0, "t5_if", c);
    chk("t5_done_cyc", c - t0, 7);
    chk("t5_en_cyc", en_cyc - t0, 4);
    step();
    if_req = 0;
    chk("t5_one_done", n_ifd - n0, 1);
    chk("t5_rdata", if_rdata, 16'hC3F3);

    // MEM_LAT=1 instance
    step();
    t0 = cyc; if_addr1 = 16'h0040; if_req1 = 1;
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en1 === 1'b1) n0 = cyc;
      if (if_done1 === 1'b1) begin c = cyc; break; end
    end
    chk("t6_en_cyc", n0 - t0, 1);
    chk("t6_done_cyc", c - t0, 3);
    chk("t6_rdata", if_rdata1, 16'h5A5A);
    step();
    if_req1 = 0;

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-port instruction/data memory between the IF stage (read-only) and the MEM stage (read/write) of the 16-bit pipelined CPU. It serialises accesses with a fixed-latency FSM, returns read data and a one-cycle done pulse to the owning stage, and drives per-stage stall signals that freeze the pipeline while an access is outstanding. The MEM stage has priority; an optional starvation guard bounds the time IF can be held off.

## Interface
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 2, memory read/write latency in cycles, legal range ≥1
- STARVE_MAX, 4, consecutive MEM wins tolerated while IF waits (guard only)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  IF fetch request; held with stable if_addr until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction; valid in if_done cycle, held until next if_done
- if_done  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_done
- d_req  in  1  MEM-stage request; held with stable d_we/d_addr/d_wdata until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  load data; valid in d_done cycle, held until next read d_done
- d_done  out  1  one-cycle completion pulse for MEM stage
- d_stall  out  1  d_req & ~d_done
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data, valid in cycle MEM_LAT after the mem_en cycle
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if d_req (or guard forces IF) grant that port, else if if_req grant IF, else stay. Grant latches owner, addr, we, wdata → ISSUE.
- ISSUE: mem_en=1, mem_we=owner_we, mem_addr/mem_wdata from latch; load counter MEM_LAT → WAIT.
- WAIT: count down; on last WAIT cycle capture mem_rdata into owner's rdata register (reads only) → DONE.
- DONE: assert owner's done; requests not arbitrated in this cycle → IDLE.
- Writes: d_rdata unchanged; IF never writes (mem_we=0 for IF owner).
- Stall outputs combinational; all other outputs registered.
- Reset: state IDLE; mem_en, mem_we, if_done, d_done, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata, starvation counter = 0. if_stall/d_stall still follow requests.
- Reset mid-access: access abandoned, mem_en drops immediately, no done issued; requester keeps req high and is re-served after reset.
- Request dropped before done: protocol violation; arbiter completes the access anyway and pulses done.

## Timing
- Request sampled in IDLE at cycle 0 → mem_en cycle 1 → WAIT cycles 2..MEM_LAT+1 → done cycle MEM_LAT+2.
- Occupancy per access MEM_LAT+3 cycles including return to IDLE; next grant earliest in cycle MEM_LAT+3, mem_en in MEM_LAT+4.
- Simultaneous if_req & d_req in IDLE: MEM stage wins (unless guard forces IF).

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter increments on each MEM grant while if_req is high; at STARVE_MAX the next IDLE arbitration with if_req high grants IF; counter clears on IF grant or when if_req is low.
- Undefined: strict MEM-stage priority, no counter logic; IF may starve indefinitely.

## Structure
- Shared package cpu_mem_pkg: FSM state enum, owner encoding (OWN_IF, OWN_D), default AW/DW constants.
- One sub-module: mem_arb_lat_cnt (loadable down-counter with last-cycle flag), reused for MEM_LAT countdown.

## Test plan
- Single IF read, MEM_LAT=2, if_addr=0x0010, mem_rdata=0x1234 → mem_en cycle 1, if_done + if_rdata=0x1234 in cycle 4, if_stall high cycles 0–3.
- d_req write 0x00A0←0xBEEF → mem_en&mem_we cycle 1, mem_addr=0x00A0, mem_wdata=0xBEEF, d_done cycle 4, d_rdata unchanged.
- if_req & d_req both held from cycle 0 → D served first (d_done cycle 4), IF issued cycle 6, if_done cycle 9.
- d_req held continuously with if_req, guard on, STARVE_MAX=4 → four D grants then IF granted; guard off → IF never granted.
- rst pulsed during WAIT of a read → mem_en=0, no done, busy=0 immediately; after release, same request re-issued and completes MEM_LAT+2 cycles after sampling.
- MEM_LAT=1 read → done in cycle 3, data captured from mem_rdata in cycle 2.
